// File: rtl/fnp_tag_replace_mp.sv
// Per-port TSN tag replacement for fragmented packets: head fragments load a tag,
// in-sequence followers reuse it, gaps and orphans are dropped with per-port pulses.
module fnp_tag_replace_mp #(
   parameter int NPORT   = 8,
   parameter int PORT_W  = 4,
   parameter int DW      = 134,
   parameter int TAGW    = 48,
   parameter int SEQW    = 4,
   parameter int TAG_LSB = 80
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     iv_pkt_data,
   input  logic              i_pkt_empty,
   output logic              o_pkt_rd,
   input  logic [TAGW-1:0]   iv_tag_data,
   input  logic [SEQW-1:0]   iv_tag_seq,
   input  logic [PORT_W-1:0] iv_tag_inport,
   input  logic              i_tag_empty,
   output logic              o_tag_rd,
   output logic [DW-1:0]     ov_pkt_data,
   output logic              o_pkt_wr,
   input  logic              i_out_afull,
   output logic [NPORT-1:0]  ov_lost_head,
   output logic [NPORT-1:0]  ov_lost_nothead,
   output logic              o_fmt_err
);

   localparam int NSLOT = 1 << PORT_W;
   localparam logic [PORT_W:0] NPORT_V = NPORT[PORT_W:0];
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b10;

   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   state_t             state_q, state_d;
   logic               first_q, first_d;
   logic [TAGW-1:0]    sel_tag_q, sel_tag_d;
   logic [DW-1:0]      data_q, data_d;
   logic               wr_q, wr_d;
   logic [NPORT-1:0]   lost_head_q, lost_head_d;
   logic [NPORT-1:0]   lost_nothead_q, lost_nothead_d;
   logic               fmt_q, fmt_d;
   logic               pkt_rd, tag_rd;

   logic [TAGW-1:0]    tag_all [NSLOT];
   logic [SEQW-1:0]    exp_all [NSLOT];
   logic               ctx_all [NSLOT];
   logic [TAGW-1:0]    cur_tag;
   logic [SEQW-1:0]    cur_exp;
   logic               cur_ctx;
   logic               port_ok;
   logic [NPORT-1:0]   port_1h;
   logic               ctx_wr;
   logic [TAGW-1:0]    tag_new;
   logic [SEQW-1:0]    exp_new;
   logic               ctx_new;
   logic [1:0]         wtype;
   logic [DW-1:0]      word_rep;

   assign cur_tag = tag_all[iv_tag_inport];
   assign cur_exp = exp_all[iv_tag_inport];
   assign cur_ctx = ctx_all[iv_tag_inport];
   assign port_ok = ({1'b0, iv_tag_inport} < NPORT_V);
   assign port_1h = NPORT'(1) << iv_tag_inport;
   assign wtype   = iv_pkt_data[DW-1:DW-2];

   // Slots beyond NPORT read as an empty context so an illegal inport never matches.
   for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NPORT) begin : g_port
         logic [TAGW-1:0] tag_q;
         logic [SEQW-1:0] exp_q;
         logic            ctx_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               tag_q <= '0;
               exp_q <= '0;
               ctx_q <= 1'b0;
            end else if (ctx_wr && port_1h[gi]) begin
               tag_q <= tag_new;
               exp_q <= exp_new;
               ctx_q <= ctx_new;
            end
         end
         assign tag_all[gi] = tag_q;
         assign exp_all[gi] = exp_q;
         assign ctx_all[gi] = ctx_q;
      end else begin : g_unused
         assign tag_all[gi] = '0;
         assign exp_all[gi] = '0;
         assign ctx_all[gi] = 1'b0;
      end
   end

   always_comb begin
      state_d        = state_q;
      first_d        = first_q;
      sel_tag_d      = sel_tag_q;
      data_d         = data_q;
      wr_d           = 1'b0;
      lost_head_d    = '0;
      lost_nothead_d = '0;
      fmt_d          = 1'b0;
      pkt_rd         = 1'b0;
      tag_rd         = 1'b0;
      ctx_wr         = 1'b0;
      tag_new        = cur_tag;
      exp_new        = cur_exp;
      ctx_new        = cur_ctx;
      word_rep       = iv_pkt_data;
      word_rep[TAG_LSB +: TAGW] = sel_tag_q;
      case (state_q)
         IDLE: begin
            if (!i_tag_empty && !i_pkt_empty && !i_out_afull) begin
               tag_rd  = 1'b1;
               first_d = 1'b1;
               state_d = DROP;
               if (!port_ok) begin
                  fmt_d = 1'b1;
               end else if (iv_tag_seq == '0) begin
                  ctx_wr    = 1'b1;
                  tag_new   = iv_tag_data;
                  exp_new   = SEQW'(1);
                  ctx_new   = 1'b1;
                  sel_tag_d = iv_tag_data;
                  state_d   = FWD;
               end else if (!cur_ctx) begin
                  lost_head_d = port_1h;
               end else if (iv_tag_seq != cur_exp) begin
                  ctx_wr         = 1'b1;
                  ctx_new        = 1'b0;
                  lost_nothead_d = port_1h;
               end else begin
                  // The last sequence number closes the context: seq wrap is not allowed.
                  ctx_wr    = 1'b1;
                  exp_new   = iv_tag_seq + 1'b1;
                  ctx_new   = (iv_tag_seq != '1);
                  sel_tag_d = cur_tag;
                  state_d   = FWD;
               end
            end
         end
         FWD: begin
            if (!i_pkt_empty) begin
               pkt_rd  = 1'b1;
               first_d = 1'b0;
               if (first_q && wtype != T_HEAD) begin
                  fmt_d   = 1'b1;
                  state_d = DROP;
               end else begin
                  wr_d   = 1'b1;
                  data_d = first_q ? word_rep : iv_pkt_data;
               end
               if (wtype == T_TAIL) state_d = IDLE;
            end
         end
         DROP: begin
            if (!i_pkt_empty) begin
               pkt_rd = 1'b1;
               if (wtype == T_TAIL) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         first_q        <= 1'b0;
         sel_tag_q      <= '0;
         data_q         <= '0;
         wr_q           <= 1'b0;
         lost_head_q    <= '0;
         lost_nothead_q <= '0;
         fmt_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         first_q        <= first_d;
         sel_tag_q      <= sel_tag_d;
         data_q         <= data_d;
         wr_q           <= wr_d;
         lost_head_q    <= lost_head_d;
         lost_nothead_q <= lost_nothead_d;
         fmt_q          <= fmt_d;
      end
   end

   // FIFO acknowledges are combinational, so hold them off while reset is asserted.
   assign o_pkt_rd        = pkt_rd & ~rst;
   assign o_tag_rd        = tag_rd & ~rst;
   assign ov_pkt_data     = data_q;
   assign o_pkt_wr        = wr_q;
   assign ov_lost_head    = lost_head_q;
   assign ov_lost_nothead = lost_nothead_q;
   assign o_fmt_err       = fmt_q;

endmodule

// File: tb/tb_fnp_tag_replace_mp.sv
// Directed bench for fnp_tag_replace_mp: the bench plays both show-ahead FIFOs
// and checks every written word, pulse and acknowledge against hand-built expectations.
module tb_fnp_tag_replace_mp;

   logic         clk = 1'b0;
   logic         rst;
   logic [133:0] iv_pkt_data;
   logic         i_pkt_empty;
   logic         o_pkt_rd;
   logic [47:0]  iv_tag_data;
   logic [3:0]   iv_tag_seq;
   logic [3:0]   iv_tag_inport;
   logic         i_tag_empty;
   logic         o_tag_rd;
   logic [133:0] ov_pkt_data;
   logic         o_pkt_wr;
   logic         i_out_afull;
   logic [7:0]   ov_lost_head;
   logic [7:0]   ov_lost_nothead;
   logic         o_fmt_err;

   fnp_tag_replace_mp dut (
      .clk            (clk),
      .rst            (rst),
      .iv_pkt_data    (iv_pkt_data),
      .i_pkt_empty    (i_pkt_empty),
      .o_pkt_rd       (o_pkt_rd),
      .iv_tag_data    (iv_tag_data),
      .iv_tag_seq     (iv_tag_seq),
      .iv_tag_inport  (iv_tag_inport),
      .i_tag_empty    (i_tag_empty),
      .o_tag_rd       (o_tag_rd),
      .ov_pkt_data    (ov_pkt_data),
      .o_pkt_wr       (o_pkt_wr),
      .i_out_afull    (i_out_afull),
      .ov_lost_head   (ov_lost_head),
      .ov_lost_nothead(ov_lost_nothead),
      .o_fmt_err      (o_fmt_err)
   );

   always #5 clk = ~clk;

   int unsigned  applied = 0;
   int unsigned  miscompares = 0;
   logic [133:0] pq[$];
   logic [133:0] sq[$];
   logic [133:0] wq[$];
   bit           tag_present;
   bit           stall_mode;
   bit           mid_afull;
   int           afull_cycles;
   int           cyc;
   logic [7:0]   lh_acc, lnh_acc;
   int           fmt_cnt, tag_rd_cnt, early_cnt;

   task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
      applied++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [133:0] mkword(input logic [1:0] t, input int port, input int seq, input int i);
      logic [32:0] v;
      v = 33'(port * 4096 + seq * 256 + i * 16) ^ 33'h1_5A5A_C3C3;
      return {t, v, ~v, v + 33'd7, v ^ 33'h0_FFFF_0000};
   endfunction

   // One clock: collect registered outputs, drive FIFO fronts, pop what the DUT acknowledged.
   task automatic cycle();
      logic rd, trd;
      @(negedge clk);
      if (o_pkt_wr) wq.push_back(ov_pkt_data);
      lh_acc  |= ov_lost_head;
      lnh_acc |= ov_lost_nothead;
      if (o_fmt_err) fmt_cnt++;
      i_pkt_empty = (pq.size() == 0) || (stall_mode && (cyc % 2 == 1));
      iv_pkt_data = (pq.size() != 0) ? pq[0] : '0;
      i_tag_empty = !tag_present;
      i_out_afull = (cyc < afull_cycles) || (mid_afull && !tag_present);
      #1;
      rd  = o_pkt_rd;
      trd = o_tag_rd;
      if (trd) tag_rd_cnt++;
      if (cyc < afull_cycles && (rd || trd)) early_cnt++;
      @(posedge clk);
      if (rd && pq.size() != 0) void'(pq.pop_front());
      if (trd) tag_present = 1'b0;
      cyc++;
   endtask

   task automatic clear_acc();
      wq.delete();
      lh_acc = '0; lnh_acc = '0;
      fmt_cnt = 0; tag_rd_cnt = 0; early_cnt = 0;
   endtask

   task automatic send(input int port, input int seq, input logic [47:0] tag, input int nw,
                       input logic [1:0] htype, input int afc, input bit stl);
      int n;
      logic [1:0] t;
      clear_acc();
      sq.delete();
      for (int i = 0; i < nw; i++) begin
         t = (i == 0) ? htype : ((i == nw - 1) ? 2'b10 : 2'b11);
         sq.push_back(mkword(t, port, seq, i));
      end
      pq = sq;
      iv_tag_inport = 4'(port);
      iv_tag_seq    = 4'(seq);
      iv_tag_data   = tag;
      tag_present   = 1'b1;
      cyc = 0; afull_cycles = afc; stall_mode = stl; mid_afull = stl;
      n = 0;
      while ((pq.size() != 0 || tag_present) && n < 200) begin
         cycle();
         n++;
      end
      repeat (3) cycle();
      check("completes_in_budget", 134'(n < 200), 134'(1));
      $display("pkt port=%0d seq=%0d words=%0d writes=%0d lh=%h lnh=%h fmt=%0d",
               port, seq, nw, wq.size(), lh_acc, lnh_acc, fmt_cnt);
   endtask

   task automatic exp_fwd(input logic [47:0] tag);
      logic [133:0] e;
      check("fwd_tag_rd_once", 134'(tag_rd_cnt), 134'(1));
      check("fwd_write_count", 134'(wq.size()), 134'(sq.size()));
      check("fwd_no_pulses", {lh_acc, lnh_acc, 32'(fmt_cnt)}, '0);
      for (int i = 0; i < sq.size() && i < wq.size(); i++) begin
         e = sq[i];
         if (i == 0) e[127:80] = tag;
         check("fwd_word", wq[i], e);
      end
   endtask

   task automatic exp_drop(input logic [7:0] lh, input logic [7:0] lnh, input int fmt);
      check("drop_tag_rd_once", 134'(tag_rd_cnt), 134'(1));
      check("drop_no_writes", 134'(wq.size()), 134'(0));
      check("drop_lost_head", 134'(lh_acc), 134'(lh));
      check("drop_lost_nothead", 134'(lnh_acc), 134'(lnh));
      check("drop_fmt_err", 134'(fmt_cnt), 134'(fmt));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pq.delete();
      tag_present = 1'b0;
      i_tag_empty = 1'b1;
      i_pkt_empty = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; iv_pkt_data = '0; i_pkt_empty = 1'b1; iv_tag_data = '0;
      iv_tag_seq = '0; iv_tag_inport = '0; i_tag_empty = 1'b1; i_out_afull = 1'b0;
      tag_present = 1'b0; stall_mode = 1'b0; mid_afull = 1'b0; afull_cycles = 0; cyc = 0;
      clear_acc();
      do_reset();
      #1;
      check("reset_outputs", {o_pkt_wr, o_pkt_rd, o_tag_rd, o_fmt_err, ov_lost_head, ov_lost_nothead}, '0);
      check("reset_data", ov_pkt_data, '0);

      // Head, follower, gap, orphan on port 2.
      send(2, 0, 48'h0123456789AB, 3, 2'b01, 0, 1'b0);
      exp_fwd(48'h0123456789AB);
      send(2, 1, 48'hFFFF_0000_FFFF, 2, 2'b01, 0, 1'b0);
      exp_fwd(48'h0123456789AB);
      send(2, 3, 48'h1111_2222_3333, 2, 2'b01, 0, 1'b0);
      exp_drop(8'h00, 8'h04, 0);
      send(2, 4, 48'h1111_2222_3333, 2, 2'b01, 0, 1'b0);
      exp_drop(8'h04, 8'h00, 0);

      // Orphan fragment right after reset.
      do_reset();
      send(5, 2, 48'hABCD_EF01_2345, 4, 2'b01, 0, 1'b0);
      exp_drop(8'h20, 8'h00, 0);
      check("orphan_all_popped", 134'(pq.size()), 134'(0));

      // Backpressure before start is honoured; stalls and afull after start are tolerated.
      send(1, 0, 48'h5555_AAAA_5555, 5, 2'b01, 6, 1'b1);
      check("afull_blocks_start", 134'(early_cnt), 134'(0));
      exp_fwd(48'h5555_AAAA_5555);

      // Bad head type, then the same port still accepts a good head.
      send(3, 0, 48'h0BAD_0BAD_0BAD, 3, 2'b11, 0, 1'b0);
      exp_drop(8'h00, 8'h00, 1);
      send(3, 0, 48'h600D_600D_600D, 2, 2'b01, 0, 1'b0);
      exp_fwd(48'h600D_600D_600D);

      // Illegal inport.
      send(9, 0, 48'h9999_9999_9999, 2, 2'b01, 0, 1'b0);
      exp_drop(8'h00, 8'h00, 1);

      // A second head replaces an unfinished context.
      send(4, 0, 48'hAAAA_0000_0001, 2, 2'b01, 0, 1'b0);
      exp_fwd(48'hAAAA_0000_0001);
      send(4, 0, 48'hBBBB_0000_0002, 2, 2'b01, 0, 1'b0);
      exp_fwd(48'hBBBB_0000_0002);
      send(4, 1, 48'hCCCC_0000_0003, 3, 2'b01, 0, 1'b0);
      exp_fwd(48'hBBBB_0000_0002);

      // Full sequence range on port 0; the last number closes the context.
      for (int s = 0; s < 16; s++) begin
         send(0, s, 48'h0000_CAFE_F00D + 48'(s), 2, 2'b01, 0, 1'b0);
         exp_fwd(48'h0000_CAFE_F00D);
      end
      send(0, 1, 48'h1234_1234_1234, 2, 2'b01, 0, 1'b0);
      exp_drop(8'h01, 8'h00, 0);

      // Reset in the middle of a forwarded packet.
      clear_acc();
      sq.delete();
      for (int i = 0; i < 6; i++) sq.push_back(mkword((i == 0) ? 2'b01 : ((i == 5) ? 2'b10 : 2'b11), 6, 0, i));
      pq = sq;
      iv_tag_inport = 4'd6; iv_tag_seq = 4'd0; iv_tag_data = 48'h6666_6666_6666;
      tag_present = 1'b1; cyc = 0; afull_cycles = 0; stall_mode = 1'b0; mid_afull = 1'b0;
      n = 0;
      while (wq.size() < 2 && n < 50) begin
         cycle();
         n++;
      end
      check("midfwd_writes_seen", 134'(wq.size()), 134'(2));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midfwd_reset_outputs", {o_pkt_wr, o_pkt_rd, o_tag_rd, o_fmt_err, ov_lost_head, ov_lost_nothead}, '0);
      check("midfwd_reset_data", ov_pkt_data, '0);
      @(negedge clk);
      rst = 1'b0;
      pq.delete();
      tag_present = 1'b0;
      send(6, 1, 48'h7777_7777_7777, 2, 2'b01, 0, 1'b0);
      exp_drop(8'h40, 8'h00, 0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
